// File: rtl/crc_32_fcs_appender.sv
// crc_32_fcs_appender: passes a byte-stream payload through and appends its Ethernet CRC-32 FCS.
// Payload bytes pass through combinationally; the four FCS bytes follow, least significant byte first.
module crc_32_fcs_appender #(
    parameter int MAX_FRAME_LEN = 1518,
    parameter int LEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic [31:0]      fcs_out,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_done,
    output logic             frame_too_long
);
    localparam logic [31:0] CRC_POLY          = 32'h04C11DB7;
    localparam logic [31:0] CRC_INITIAL_VALUE = 32'hFFFFFFFF;

    typedef enum logic {PAYLOAD, FCS} state_t;

    function automatic logic [7:0] revers_byts(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    function automatic logic [31:0] not_reverse_4_byts(input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = ~c[31-i];
        return r;
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] din);
        logic [31:0] r;
        logic        b;
        r = c;
        for (int k = 0; k < 8; k++) begin
            b = r[31] ^ din[7-k];
            r = {r[30:0], 1'b0} ^ (b ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      crc_q, crc_d, fcs_q, fcs_d, fcs_out_q, fcs_out_d, crc_next;
    logic [LEN_W-1:0] len_q, len_d, frame_len_q, frame_len_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             s_acc, f_acc;

    assign s_ready        = !rst && state_q == PAYLOAD && m_ready;
    assign m_valid        = !rst && (state_q == FCS || s_valid);
    assign m_data         = state_q == FCS ? fcs_q[{cnt_q, 3'b000} +: 8] : s_data;
    assign m_last         = state_q == FCS && cnt_q == 2'd3;
    assign s_acc          = s_valid && s_ready;
    assign f_acc          = !rst && state_q == FCS && m_ready;
    assign frame_done     = f_acc && cnt_q == 2'd3;
    assign frame_too_long = s_acc && len_q == LEN_W'(MAX_FRAME_LEN);
    assign fcs_out        = fcs_out_q;
    assign frame_len      = frame_len_q;
    assign crc_next       = crc_step(crc_q, revers_byts(s_data));

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        len_d       = len_q;
        fcs_d       = fcs_q;
        cnt_d       = cnt_q;
        fcs_out_d   = fcs_out_q;
        frame_len_d = frame_len_q;
        if (s_acc) begin
            crc_d = crc_next;
            len_d = &len_q ? len_q : len_q + 1'b1;
            if (s_last) begin
                state_d = FCS;
                cnt_d   = 2'd0;
                fcs_d   = not_reverse_4_byts(crc_next);
            end
        end
        if (f_acc) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                fcs_out_d   = fcs_q;
                frame_len_d = len_q;
                crc_d       = CRC_INITIAL_VALUE;
                len_d       = '0;
                state_d     = PAYLOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PAYLOAD;
            crc_q       <= CRC_INITIAL_VALUE;
            len_q       <= '0;
            fcs_q       <= '0;
            cnt_q       <= '0;
            fcs_out_q   <= '0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            fcs_q       <= fcs_d;
            cnt_q       <= cnt_d;
            fcs_out_q   <= fcs_out_d;
            frame_len_q <= frame_len_d;
        end
    end
endmodule
